// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: merges ALU results with queued load results.
// Optional combinational write-forwarding to decode is enabled by defining WB_BYPASS_EN.

// Load-result queue: power-of-two ring buffer holding {addr, data} entries.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller must not push when count == DEPTH or pop when count == 0.
module wb_lq_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Single write-port arbiter: AluStall forced drain > ALU > queued load.
// Latency: grant in cycle N drives WriteEnable/WriteAddr/WriteData in N+1.
// Backpressure: LdReady from registered queue count; AluStall holds off the ALU.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        AluValid,
  input  logic [ADDR_W-1:0]           AluAddr,
  input  logic [DATA_W-1:0]           AluData,
  output logic                        AluStall,
  input  logic                        LdValid,
  output logic                        LdReady,
  input  logic [ADDR_W-1:0]           LdAddr,
  input  logic [DATA_W-1:0]           LdData,
  output logic                        WriteEnable,
  output logic [ADDR_W-1:0]           WriteAddr,
  output logic [DATA_W-1:0]           WriteData,
`ifdef WB_BYPASS_EN
  input  logic [ADDR_W-1:0]           ReadAddr1,
  input  logic [ADDR_W-1:0]           ReadAddr2,
  input  logic [DATA_W-1:0]           RfData1,
  input  logic [DATA_W-1:0]           RfData2,
  output logic [DATA_W-1:0]           FwdData1,
  output logic [DATA_W-1:0]           FwdData2,
`endif
  output logic [$clog2(LQ_DEPTH):0]   QueueCount,
  output logic                        Error
);
  localparam int CNT_W = $clog2(LQ_DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  wb_ent_t          ld_ent;
  wb_ent_t          lq_head;
  wb_ent_t          grant_ent;
  logic [CNT_W-1:0] lq_count;
  logic             lq_empty;
  logic             push;
  logic             pop;
  logic             alu_grant;
  logic             grant_vld;
  logic [ST_W-1:0]  starve_cnt;
  logic [ST_W-1:0]  starve_nxt;
  logic             stall_q;
  logic             stall_nxt;

  assign ld_ent   = '{addr: LdAddr, data: LdData};
  assign LdReady  = (lq_count != CNT_W'(LQ_DEPTH));
  assign push     = LdValid && LdReady;
  assign lq_empty = (lq_count == '0);

  wb_lq_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (ld_ent),
    .pop      (pop),
    .head_dat (lq_head),
    .count    (lq_count)
  );

  // An ALU result offered during the stall cycle gets no grant (it is dropped).
  always_comb begin
    pop       = 1'b0;
    alu_grant = 1'b0;
    grant_vld = 1'b0;
    grant_ent = lq_head;
    if (stall_q && !lq_empty) begin
      pop       = 1'b1;
      grant_vld = 1'b1;
    end else if (AluValid && !stall_q) begin
      alu_grant = 1'b1;
      grant_vld = 1'b1;
      grant_ent = '{addr: AluAddr, data: AluData};
    end else if (!lq_empty) begin
      pop       = 1'b1;
      grant_vld = 1'b1;
    end
  end

  // Reaching STARVE_MAX ALU grants raises the stall for the following cycle.
  always_comb begin
    starve_nxt = starve_cnt;
    stall_nxt  = 1'b0;
    if (lq_empty || pop) begin
      starve_nxt = '0;
    end else if (alu_grant) begin
      if (starve_cnt == ST_W'(STARVE_MAX - 1)) begin
        stall_nxt  = 1'b1;
        starve_nxt = '0;
      end else begin
        starve_nxt = starve_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt  <= '0;
      stall_q     <= 1'b0;
      WriteEnable <= 1'b0;
      WriteAddr   <= '0;
      WriteData   <= '0;
      Error       <= 1'b0;
    end else begin
      starve_cnt  <= starve_nxt;
      stall_q     <= stall_nxt;
      WriteEnable <= grant_vld && (grant_ent.addr != '0);
      if (grant_vld && (grant_ent.addr != '0)) begin
        WriteAddr <= grant_ent.addr;
        WriteData <= grant_ent.data;
      end
      if (AluValid && stall_q) begin
        Error <= 1'b1;
      end
    end
  end

  assign AluStall   = stall_q;
  assign QueueCount = lq_count;

`ifdef WB_BYPASS_EN
  // Covers the write that the register file has not committed yet.
  assign FwdData1 = (WriteEnable && (WriteAddr == ReadAddr1) && (ReadAddr1 != '0)) ? WriteData : RfData1;
  assign FwdData2 = (WriteEnable && (WriteAddr == ReadAddr2) && (ReadAddr2 != '0)) ? WriteData : RfData2;
`endif

  a_stall_nonempty: assert property (@(posedge clk) disable iff (rst) stall_q |-> !lq_empty);
  a_count_bound:    assert property (@(posedge clk) disable iff (rst) lq_count <= CNT_W'(LQ_DEPTH));
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: expected writes are queued with their due cycle.
module tb_wb_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int LQ_DEPTH   = 4;
  localparam int STARVE_MAX = 8;
  localparam int CNT_W      = $clog2(LQ_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              AluValid = 1'b0;
  logic [ADDR_W-1:0] AluAddr = '0;
  logic [DATA_W-1:0] AluData = '0;
  logic              AluStall;
  logic              LdValid = 1'b0;
  logic              LdReady;
  logic [ADDR_W-1:0] LdAddr = '0;
  logic [DATA_W-1:0] LdData = '0;
  logic              WriteEnable;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic [CNT_W-1:0]  QueueCount;
  logic              Error;
`ifdef WB_BYPASS_EN
  logic [ADDR_W-1:0] ReadAddr1 = '0;
  logic [ADDR_W-1:0] ReadAddr2 = '0;
  logic [DATA_W-1:0] RfData1 = '0;
  logic [DATA_W-1:0] RfData2 = '0;
  logic [DATA_W-1:0] FwdData1;
  logic [DATA_W-1:0] FwdData2;
`endif

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluStall(AluStall),
    .LdValid(LdValid), .LdReady(LdReady), .LdAddr(LdAddr), .LdData(LdData),
    .WriteEnable(WriteEnable), .WriteAddr(WriteAddr), .WriteData(WriteData),
`ifdef WB_BYPASS_EN
    .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2), .RfData1(RfData1), .RfData2(RfData2),
    .FwdData1(FwdData1), .FwdData2(FwdData2),
`endif
    .QueueCount(QueueCount), .Error(Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    AluValid = 1'b0;
    LdValid  = 1'b0;
  endtask

  task automatic exp_wr(input int a, input logic [31:0] d, input int due);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.due  = due;
    sb.push_back(e);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (WriteEnable === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got addr=%0d data=%0h cycle=%0d want no write",
                 WriteAddr, WriteData, cyc);
      end else begin
        e = sb.pop_front();
        if (WriteAddr !== e.addr[ADDR_W-1:0] || WriteData !== e.data || cyc != e.due) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%0h cycle=%0d want addr=%0d data=%0h cycle=%0d",
                   WriteAddr, WriteData, cyc, e.addr, e.data, e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("rst_we",     WriteEnable, 0);
    check("rst_stall",  AluStall,    0);
    check("rst_qcnt",   QueueCount,  0);
    check("rst_err",    Error,       0);
    check("rst_waddr",  WriteAddr,   0);
    check("rst_wdata",  WriteData,   0);
    rst = 1'b0;
    tick();
    check("post_rst_ldready", LdReady,     1);
    check("post_rst_we",      WriteEnable, 0);
    check("post_rst_qcnt",    QueueCount,  0);

    // Single ALU write
    AluValid = 1'b1; AluAddr = 5'd3; AluData = 32'h1234;
    exp_wr(3, 32'h1234, cyc + 1);
    tick();
    idle();
    check("alu_we", WriteEnable, 1);
    tick();

    // Fill the queue under continuous ALU traffic; forced drain after 8 grants
    for (int i = 0; i < 10; i++) begin
      AluValid = (i < 9);
      AluAddr  = ADDR_W'(10 + i);
      AluData  = 32'h100 + i;
      LdValid  = (i < 5);
      LdAddr   = ADDR_W'(5 + i);
      LdData   = 32'hB00 + i;
      if (i < 9) exp_wr(10 + i, 32'h100 + i, cyc + 1);
      if (i == 4) begin
        check("full_ldready", LdReady,    0);
        check("full_qcnt",    QueueCount, 4);
      end
      if (i == 8) check("pre_stall", AluStall, 0);
      if (i == 9) begin
        check("stall_hi",   AluStall,   1);
        check("stall_qcnt", QueueCount, 4);
        for (int j = 0; j < 4; j++) exp_wr(5 + j, 32'hB00 + j, cyc + 1 + j);
      end
      tick();
    end
    idle();
    check("stall_one_cycle", AluStall,   0);
    check("drain_qcnt3",     QueueCount, 3);
    tick();
    tick();
    tick();
    check("drain_qcnt0",    QueueCount, 0);
    check("drain_ldready",  LdReady,    1);
    tick();

    // Lone load: written two cycles after the push
    LdValid = 1'b1; LdAddr = 5'd9; LdData = 32'hCAFE;
    exp_wr(9, 32'hCAFE, cyc + 2);
    tick();
    idle();
    check("lone_qcnt1", QueueCount, 1);
    tick();
    check("lone_qcnt0", QueueCount, 0);
    tick();

    // Register 0 never written, from ALU or from the queue
    AluValid = 1'b1; AluAddr = 5'd0; AluData = 32'hFFFF;
    tick();
    idle();
    check("r0_alu_we", WriteEnable, 0);
    LdValid = 1'b1; LdAddr = 5'd0; LdData = 32'h5A5A;
    tick();
    idle();
    check("r0_ld_qcnt1", QueueCount, 1);
    tick();
    check("r0_ld_qcnt0", QueueCount, 0);
    check("r0_ld_we",    WriteEnable, 0);
    tick();

    // ALU result offered during the stall cycle is dropped and flags Error
    for (int i = 0; i < 10; i++) begin
      AluValid = 1'b1;
      AluAddr  = ADDR_W'(20 + i);
      AluData  = 32'h300 + i;
      LdValid  = (i == 0);
      LdAddr   = 5'd12;
      LdData   = 32'h55;
      if (i < 9) exp_wr(20 + i, 32'h300 + i, cyc + 1);
      if (i == 9) begin
        check("err_stall_hi", AluStall, 1);
        check("err_pre",      Error,    0);
        exp_wr(12, 32'h55, cyc + 1);
      end
      tick();
    end
    idle();
    check("err_set",     Error,      1);
    check("err_qcnt",    QueueCount, 0);
    check("err_stall_lo", AluStall,  0);
    tick();
    tick();
    check("err_sticky", Error, 1);

    // Reset mid-operation discards queued loads
    AluValid = 1'b1; AluAddr = 5'd14; AluData = 32'h400;
    LdValid  = 1'b1; LdAddr  = 5'd15; LdData  = 32'h401;
    exp_wr(14, 32'h400, cyc + 1);
    tick();
    AluAddr = 5'd16; AluData = 32'h402; LdAddr = 5'd17; LdData = 32'h403;
    exp_wr(16, 32'h402, cyc + 1);
    tick();
    idle();
    check("mid_qcnt2", QueueCount, 2);
    rst = 1'b1;
    tick();
    check("mid_rst_we",   WriteEnable, 0);
    check("mid_rst_qcnt", QueueCount,  0);
    check("mid_rst_err",  Error,       0);
    rst = 1'b0;
    tick();
    check("mid_rst_ldready", LdReady, 1);
    repeat (4) tick();

`ifdef WB_BYPASS_EN
    AluValid = 1'b1; AluAddr = 5'd4; AluData = 32'hAA;
    exp_wr(4, 32'hAA, cyc + 1);
    tick();
    idle();
    ReadAddr1 = 5'd4; RfData1 = 32'h11; ReadAddr2 = 5'd5; RfData2 = 32'h22;
    #1;
    check("fwd1_hit",  FwdData1, 32'hAA);
    check("fwd2_miss", FwdData2, 32'h22);
    ReadAddr1 = 5'd0;
    #1;
    check("fwd1_r0", FwdData1, 32'h11);
    tick();
`endif

    repeat (3) tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d outstanding writes want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
